// File: rtl/hsync_gen_if.sv
// Horizontal timing bus from hsync_gen to the vertical stage and the bar renderer.
interface hsync_gen_if;
    logic       hsync;
    logic       hvalid;
    logic [8:0] cntpix;
    logic [3:0] band;
    logic [4:0] bandpix;
    logic       gap;
    logic       hend;

    modport master (
        output hsync,
        output hvalid,
        output cntpix,
        output band,
        output bandpix,
        output gap,
        output hend
    );

    modport slave (
        input hsync,
        input hvalid,
        input cntpix,
        input band,
        input bandpix,
        input gap,
        input hend
    );
endinterface

// File: rtl/hsync_gen.sv
// Horizontal timing generator for the 480x272 LCD: hsync, active window,
// pixel column and audio-bar column split. Every output is a flop loaded
// from the decode of the next line-counter value.
module hsync_gen #(
    parameter int unsigned H_TOTAL  = 525,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_START  = 43,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned BAND_W   = 30,
    parameter int unsigned GAP_W    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    hsync_gen_if.master  bus
);

    localparam int unsigned HW     = $clog2(H_TOTAL);
    localparam int unsigned H_LAST = H_START + H_ACTIVE - 1;
    localparam int unsigned N_BAND = H_ACTIVE / BAND_W;

    // Reject parameter sets the decode below cannot represent.
    if (H_START < H_SYNC) begin : g_chk_start
        $fatal(1, "hsync_gen: H_START < H_SYNC");
    end
    if (H_START + H_ACTIVE > H_TOTAL) begin : g_chk_total
        $fatal(1, "hsync_gen: H_START+H_ACTIVE > H_TOTAL");
    end
    if ((H_ACTIVE % BAND_W) != 0) begin : g_chk_band
        $fatal(1, "hsync_gen: H_ACTIVE not a multiple of BAND_W");
    end
    if (GAP_W >= BAND_W) begin : g_chk_gap
        $fatal(1, "hsync_gen: GAP_W >= BAND_W");
    end
    if (N_BAND > 16) begin : g_chk_nband
        $fatal(1, "hsync_gen: more than 16 bars");
    end
    if (H_ACTIVE > 512) begin : g_chk_active
        $fatal(1, "hsync_gen: H_ACTIVE > 512");
    end

    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_nx;
    logic          hsync_q,   hsync_nx;
    logic          hvalid_q,  hvalid_nx;
    logic [8:0]    cntpix_q,  cntpix_nx;
    logic [3:0]    band_q,    band_nx;
    logic [4:0]    bandpix_q, bandpix_nx;
    logic          gap_q,     gap_nx;
    logic          hend_q,    hend_nx;

    // Next line position and the decode of every output for that position.
    always_comb begin
        hcnt_nx    = hcnt_q + HW'(1);
        hsync_nx   = 1'b1;
        hvalid_nx  = 1'b0;
        cntpix_nx  = '0;
        band_nx    = '0;
        bandpix_nx = '0;
        gap_nx     = 1'b0;
        hend_nx    = 1'b0;

        if (hcnt_q == HW'(H_TOTAL - 1)) begin
            hcnt_nx = '0;
        end

        hsync_nx  = (hcnt_nx >= HW'(H_SYNC));
        hvalid_nx = (hcnt_nx >= HW'(H_START)) && (hcnt_nx <= HW'(H_LAST));
        hend_nx   = (hcnt_nx == HW'(H_LAST));

        if (hvalid_nx) begin
            cntpix_nx = 9'(hcnt_nx - HW'(H_START));
        end

        // Bars advance incrementally; the first active pixel restarts them.
        if (hvalid_nx && (hcnt_nx != HW'(H_START))) begin
            if (bandpix_q == 5'(BAND_W - 1)) begin
                bandpix_nx = '0;
                band_nx    = band_q + 4'd1;
            end else begin
                bandpix_nx = bandpix_q + 5'd1;
                band_nx    = band_q;
            end
        end

        gap_nx = hvalid_nx && (bandpix_nx >= 5'(BAND_W - GAP_W));
    end

    // Counter and output registers; reset parks hcnt on the last clock so the
    // first edge after release starts a line with a clean hsync fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= HW'(H_TOTAL - 1);
            hsync_q   <= 1'b1;
            hvalid_q  <= 1'b0;
            cntpix_q  <= '0;
            band_q    <= '0;
            bandpix_q <= '0;
            gap_q     <= 1'b0;
            hend_q    <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_nx;
            hsync_q   <= hsync_nx;
            hvalid_q  <= hvalid_nx;
            cntpix_q  <= cntpix_nx;
            band_q    <= band_nx;
            bandpix_q <= bandpix_nx;
            gap_q     <= gap_nx;
            hend_q    <= hend_nx;
        end
    end

    assign bus.hsync   = hsync_q;
    assign bus.hvalid  = hvalid_q;
    assign bus.cntpix  = cntpix_q;
    assign bus.band    = band_q;
    assign bus.bandpix = bandpix_q;
    assign bus.gap     = gap_q;
    assign bus.hend    = hend_q;

endmodule

// File: tb/tb_hsync_gen.sv
// Scoreboard bench for hsync_gen: stimulus queues the expected output per
// clock, a negedge monitor pops and compares.
module tb_hsync_gen;

    localparam int unsigned LINE  = 525;
    localparam int unsigned N1    = 3 * LINE + 244;
    localparam int unsigned LINES = 20;

    typedef struct packed {
        logic       hsync;
        logic       hvalid;
        logic [8:0] cntpix;
        logic [3:0] band;
        logic [4:0] bandpix;
        logic       gap;
        logic       hend;
    } out_t;

    logic clk;
    logic rst_n;

    hsync_gen_if bus ();

    hsync_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    out_t q_exp[$];
    int   q_h[$];

    int passes = 0;
    int total  = 0;
    int falls  = 0;
    int gaps   = 0;
    int hends  = 0;
    logic prev_hs = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs at line position h, from the line geometry directly.
    function automatic out_t exp_at(int h);
        out_t o;
        int   c;
        c         = h - 43;
        o.hsync   = (h > 40);
        o.hvalid  = (h >= 43) && (h <= 522);
        o.cntpix  = o.hvalid ? 9'(c) : 9'd0;
        o.band    = o.hvalid ? 4'(c / 30) : 4'd0;
        o.bandpix = o.hvalid ? 5'(c % 30) : 5'd0;
        o.gap     = o.hvalid && ((c % 30) >= 28);
        o.hend    = (h == 522);
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.hsync   = bus.hsync;
        o.hvalid  = bus.hvalid;
        o.cntpix  = bus.cntpix;
        o.band    = bus.band;
        o.bandpix = bus.bandpix;
        o.gap     = bus.gap;
        o.hend    = bus.hend;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passes++;
        else $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    task automatic push_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            q_exp.push_back(exp_at(k % LINE));
            q_h.push_back(k % LINE);
        end
    endtask

    // Monitor: one scoreboard entry per clock while out of reset.
    always @(negedge clk) begin
        out_t a;
        out_t e;
        int   h;
        if (rst_n) begin
            a = dut_out();
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                h = q_h.pop_front();
                total++;
                if (a === e) passes++;
                else $display("FAIL out_h%0d got=%h want=%h", h, a, e);
            end
            if (prev_hs && !a.hsync) falls++;
            prev_hs = a.hsync;
            if (a.gap)  gaps++;
            if (a.hend) hends++;
        end
    end

    initial begin
        out_t rst_v;
        int   f0, g0, e0;
        rst_v = '{hsync: 1'b1, default: '0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", 32'(dut_out()), 32'(rst_v));

        // Release between edges; the next edge is line position 0.
        @(posedge clk);
        #7 rst_n = 1'b1;
        push_cycles(N1);
        repeat (N1) @(posedge clk);
        @(negedge clk);
        #1 check("drain_phase1", 32'(q_exp.size()), 32'd0);
        check("at_cntpix200", 32'(bus.cntpix), 32'd200);

        // Asynchronous reset mid-active, no clock edge in between.
        rst_n = 1'b0;
        #1 check("async_reset", 32'(dut_out()), 32'(rst_v));
        repeat (3) @(posedge clk);
        #1 check("held_reset", 32'(dut_out()), 32'(rst_v));

        @(posedge clk);
        #7 rst_n = 1'b1;
        f0 = falls;
        g0 = gaps;
        e0 = hends;
        push_cycles(LINES * LINE);
        repeat (LINES * LINE) @(posedge clk);
        @(negedge clk);
        #1 check("drain_phase2", 32'(q_exp.size()), 32'd0);
        check("hsync_falls", 32'(falls - f0), 32'(LINES));
        check("gap_clocks", 32'(gaps - g0), 32'(LINES * 32));
        check("hend_pulses", 32'(hends - e0), 32'(LINES));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
